// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared constants for the programmable clock divider.
// Revision : 1.0
// ============================================================================
package clk_div_pkg;

    localparam int unsigned c_RATIO_WIDTH_DEFAULT = 8;
    // Smallest ratio that actually divides; anything below falls back to bypass.
    localparam int unsigned c_MIN_ACTIVE_RATIO    = 2;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_if
// Brief    : Control/output bundle of the clock divider.
// Revision : 1.0
// ============================================================================
interface clk_div_if
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = c_RATIO_WIDTH_DEFAULT
);

    logic                   i_clk_en;
    logic [RATIO_WIDTH-1:0] i_div_ratio;
    logic                   o_div_clk;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk
    );

endinterface : clk_div_if
`default_nettype wire

// File: rtl/clk_div_mux2.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_mux2
// Brief    : Two-input clock mux; swappable for a glitch-free library cell.
// Revision : 1.0
// ============================================================================
module clk_div_mux2 (
    input  wire logic i_clk0,
    input  wire logic i_clk1,
    input  wire logic i_sel,
    output wire logic o_clk
);

    assign o_clk = i_sel ? i_clk1 : i_clk0;

endmodule : clk_div_mux2
`default_nettype wire

// File: rtl/clk_div.sv
`default_nettype none
// ============================================================================
// Module   : clk_div
// Brief    : Programmable integer clock divider with reference-clock bypass.
// Revision : 1.0
// ============================================================================
module clk_div
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = c_RATIO_WIDTH_DEFAULT
)(
    input  wire logic  i_ref_clk,
    input  wire logic  i_rst,
    clk_div_if.slave   bus
);

    localparam logic [RATIO_WIDTH-1:0] c_MIN_RATIO = RATIO_WIDTH'(c_MIN_ACTIVE_RATIO);
    localparam logic [RATIO_WIDTH-1:0] c_ONE       = RATIO_WIDTH'(1);

    logic [RATIO_WIDTH-1:0] r_cnt;
    logic                   r_div_q;

    logic                   w_active;
    logic [RATIO_WIDTH-1:0] w_lo_len;
    logic [RATIO_WIDTH-1:0] w_hi_len;
    logic [RATIO_WIDTH-1:0] w_phase_len;
    logic                   w_phase_end;

    assign w_active    = bus.i_clk_en && (bus.i_div_ratio >= c_MIN_RATIO);
    assign w_lo_len    = bus.i_div_ratio >> 1;
    assign w_hi_len    = bus.i_div_ratio - w_lo_len;
    assign w_phase_len = r_div_q ? w_hi_len : w_lo_len;
    // ">=" lets a mid-phase ratio decrease end the phase instead of wrapping.
    assign w_phase_end = (r_cnt >= (w_phase_len - c_ONE));

    always_ff @(posedge i_ref_clk) begin
        if (i_rst || !w_active) begin
            r_cnt   <= '0;
            r_div_q <= 1'b0;
        end else if (w_phase_end) begin
            r_cnt   <= '0;
            r_div_q <= ~r_div_q;
        end else begin
            r_cnt   <= r_cnt + c_ONE;
        end
    end

    clk_div_mux2 u_out_mux (
        .i_clk0 (i_ref_clk),
        .i_clk1 (r_div_q),
        .i_sel  (w_active),
        .o_clk  (bus.o_div_clk)
    );

endmodule : clk_div
`default_nettype wire

// File: tb/tb_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div
// Brief    : Directed self-checking bench for clk_div.
// Revision : 1.0
// ============================================================================
module tb_clk_div;

    localparam int c_RATIO_WIDTH = 8;

    logic r_ref_clk = 1'b0;
    logic r_rst     = 1'b1;
    int   n_checks  = 0;
    int   n_fails   = 0;

    clk_div_if #(.RATIO_WIDTH(c_RATIO_WIDTH)) bus ();

    clk_div #(.RATIO_WIDTH(c_RATIO_WIDTH)) dut (
        .i_ref_clk (r_ref_clk),
        .i_rst     (r_rst),
        .bus       (bus)
    );

    always #5 r_ref_clk = ~r_ref_clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge r_ref_clk);
        #1;
    endtask

    // Caller guarantees the previous sampled edge started a fresh low phase.
    task automatic run_pattern(input string tag, input int n, input int lo, input int cycles);
        for (int j = 1; j <= cycles; j++) begin
            tick();
            check($sformatf("%s_j%0d", tag, j), 32'(bus.o_div_clk), 32'((j % n) >= lo));
        end
    endtask

    task automatic check_bypass(input string tag);
        @(posedge r_ref_clk);
        #1;
        check({tag, "_hi"}, 32'(bus.o_div_clk), 32'd1);
        @(negedge r_ref_clk);
        #1;
        check({tag, "_lo"}, 32'(bus.o_div_clk), 32'd0);
    endtask

    task automatic restart(input logic [7:0] ratio);
        r_rst           = 1'b1;
        bus.i_div_ratio = ratio;
        tick();
        check("reset_low", 32'(bus.o_div_clk), 32'd0);
        r_rst = 1'b0;
    endtask

    initial begin
        bus.i_clk_en    = 1'b1;
        bus.i_div_ratio = 8'd7;
        tick();
        tick();
        check("reset_state", 32'(bus.o_div_clk), 32'd0);
        r_rst = 1'b0;
        run_pattern("n7", 7, 3, 21);

        restart(8'd4);
        run_pattern("n4", 4, 2, 12);

        restart(8'd2);
        run_pattern("n2", 2, 1, 8);

        bus.i_div_ratio = 8'd0;
        check_bypass("n0_a");
        check_bypass("n0_b");
        bus.i_div_ratio = 8'd1;
        check_bypass("n1_a");
        check_bypass("n1_b");

        bus.i_clk_en    = 1'b0;
        bus.i_div_ratio = 8'd6;
        check_bypass("dis6_a");
        check_bypass("dis6_b");
        tick();
        bus.i_clk_en = 1'b1;
        #1;
        check("en_start", 32'(bus.o_div_clk), 32'd0);
        run_pattern("n6_en", 6, 3, 12);

        restart(8'd8);
        run_pattern("n8_pre", 8, 4, 6);
        r_rst = 1'b1;
        tick();
        check("mid_rst_a", 32'(bus.o_div_clk), 32'd0);
        tick();
        check("mid_rst_b", 32'(bus.o_div_clk), 32'd0);
        r_rst = 1'b0;
        run_pattern("n8_post", 8, 4, 16);

        restart(8'd255);
        run_pattern("n255", 255, 127, 385);
        bus.i_div_ratio = 8'd3;
        tick();
        check("sw_end", 32'(bus.o_div_clk), 32'd0);
        run_pattern("n3_sw", 3, 1, 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule : tb_clk_div
`default_nettype wire
